// File: rtl/cpu_pkg.sv
// Shared fetch-stage types: fetch FSM states, datapath width, PC step and the
// {pc, instr} entry carried from fetch to decode.
package cpu_pkg;

    localparam int XLEN    = 32;
    localparam int PC_INCR = 4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,  // no request outstanding
        WAIT  = 2'd1,  // one request outstanding, data will be kept
        DRAIN = 2'd2   // one request outstanding, data will be discarded
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_unit_fetch_queue.sv
// Synchronous FIFO holding fetched {pc, instr} pairs between fetch and decode.
// Simultaneous push and pop leave the count unchanged; clear empties the queue.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; count gates every read, so stale
    // words are never observed and the array can map onto plain registers/RAM.
    always_ff @(posedge clk) begin
        if (push && !clear)
            mem[wr_ptr] <= wdata;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: issues one outstanding word fetch at a time, buffers
// {pc, instr} for decode and steers the PC register. Optional: IFETCH_BYPASS_EN.
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter int XLEN     = cpu_pkg::XLEN,
    parameter int FQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_in,
    output logic            pc_write,
    output logic [XLEN-1:0] pc_next,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [XLEN-1:0]   req_pc;
    logic [CW-1:0]     count;
    logic [2*XLEN-1:0] q_head;
    logic              credit;
    logic              grant;
    logic              push;
    logic              pop;
`ifdef IFETCH_BYPASS_EN
    logic              bypass_hit;
`endif

    fetch_queue #(
        .DEPTH (FQ_DEPTH),
        .WIDTH (2*XLEN)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (redirect),
        .wdata ({req_pc, imem_rdata}),
        .head  (q_head),
        .count (count)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave a value held and infer a latch.
    always_comb begin
        state_nxt = state;

        // An outstanding request reserves a queue slot before its data returns.
        credit    = (state == FETCH) ? (count < CW'(FQ_DEPTH)) : (count < CW'(FQ_DEPTH - 1));
        imem_req  = !rst && (state != DRAIN) && !redirect && credit
                    && ((state == FETCH) || imem_rvalid);
        imem_addr = pc_in;
        grant     = imem_req && imem_gnt;

        pc_write  = !rst && (redirect || grant);
        pc_next   = redirect ? {redirect_pc[XLEN-1:2], 2'b00} : pc_in + XLEN'(PC_INCR);

`ifdef IFETCH_BYPASS_EN
        bypass_hit = !rst && (count == '0) && (state == WAIT) && imem_rvalid && !redirect;
        id_valid   = (count != '0) || bypass_hit;
        {id_pc, id_instr} = bypass_hit ? {req_pc, imem_rdata} : q_head;
        push = (state == WAIT) && imem_rvalid && !redirect && !(bypass_hit && id_ready);
`else
        id_valid   = (count != '0);
        {id_pc, id_instr} = q_head;
        push = (state == WAIT) && imem_rvalid && !redirect;
`endif
        pop = (count != '0) && id_ready && !redirect;

        unique case (state)
            FETCH: if (grant) state_nxt = WAIT;
            WAIT: begin
                if (redirect)
                    state_nxt = imem_rvalid ? FETCH : DRAIN;
                else if (imem_rvalid)
                    state_nxt = grant ? WAIT : FETCH;
            end
            // A redirect while draining keeps draining until the stale word lands.
            DRAIN: if (imem_rvalid) state_nxt = FETCH;
            default: state_nxt = FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= FETCH;
            req_pc <= '0;
        end else begin
            state <= state_nxt;
            if (grant) req_pc <= pc_in;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: behavioural PC register and instruction
// memory, expected entries queued at grant time and checked by a decode monitor.
module tb_ifetch_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        pc_write;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    int total = 0;
    int bad   = 0;

    fetch_entry_t exp_q[$];
    int           lat    = 1;
    bit           gnt_en = 1'b1;

    bit          pend = 1'b0;
    logic [31:0] paddr;
    int          cnt;

    always #5 clk = ~clk;
    assign imem_gnt = gnt_en;

    ifetch_unit #(.XLEN(32), .FQ_DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_in       (pc_in),
        .pc_write    (pc_write),
        .pc_next     (pc_next),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_instr    (id_instr),
        .id_pc       (id_pc)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a << 8) ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_grant(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = imem_req && imem_gnt;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s: no grant within 40 cycles", name);
        end
    endtask

    // PC register and instruction memory; every granted fetch is expected at decode
    // unless a redirect or reset intervenes first.
    always @(posedge clk) begin
        logic        g, w, r, rd;
        logic [31:0] a, n;
        g  = imem_req && imem_gnt;
        a  = imem_addr;
        w  = pc_write;
        n  = pc_next;
        r  = rst;
        rd = redirect;
        #1;
        if (w) pc_in = n;
        imem_rvalid = 1'b0;
        if (r) begin
            pend = 1'b0;
            exp_q.delete();
        end else begin
            if (rd) exp_q.delete();
            if (pend) begin
                if (cnt <= 1) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = instr_of(paddr);
                    pend        = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (g) begin
                exp_q.push_back('{pc: a, instr: instr_of(a)});
                if (lat <= 1) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = instr_of(a);
                end else begin
                    pend  = 1'b1;
                    paddr = a;
                    cnt   = lat - 1;
                end
            end
        end
    end

    // Decode-side monitor: each accepted entry must match the oldest expected one.
    always @(negedge clk) begin
        fetch_entry_t e;
        if (!rst && id_valid && id_ready && !redirect) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL id_unexpected: got pc 0x%08h with nothing expected", id_pc);
            end else begin
                e = exp_q.pop_front();
                check("id_pc", id_pc, e.pc);
                check("id_instr", id_instr, e.instr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] saved;
        bit          pat [8];
        bit          seen;

        rst = 1'b1; pc_in = '0; redirect = 1'b0; redirect_pc = '0;
        id_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;

        // Reset state.
        @(posedge clk);
        @(negedge clk);
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_pc_write", 32'(pc_write), 32'd0);
        tick();
        rst = 1'b0;

        // Sequential stream from PC 0: with two slots the credit stalls every third cycle.
`ifdef IFETCH_BYPASS_EN
        pat = '{1, 1, 1, 1, 1, 1, 1, 1};
`else
        pat = '{1, 1, 0, 1, 1, 0, 1, 1};
`endif
        exp_pc = 32'd4;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("seq_pc_write[%0d]", i), 32'(pc_write), 32'(pat[i]));
            if (pat[i]) begin
                check($sformatf("seq_pc_next[%0d]", i), pc_next, exp_pc);
                exp_pc += 32'd4;
            end
        end

        // Grant withheld: request holds with a stable address and no PC write.
        tick();
        gnt_en = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = imem_req;
        end
        saved = imem_addr;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("stall_req[%0d]", k), 32'(imem_req), 32'd1);
            check($sformatf("stall_pc_write[%0d]", k), 32'(pc_write), 32'd0);
            check($sformatf("stall_addr[%0d]", k), imem_addr, saved);
        end

        // Decode back-pressure: two entries buffered, fetch stops, one pop frees a slot.
        tick();
        gnt_en   = 1'b1;
        id_ready = 1'b0;
        repeat (8) @(negedge clk);
        check("bp_buffered", 32'(exp_q.size()), 32'd2);
        check("bp_req_off", 32'(imem_req), 32'd0);
        check("bp_id_valid", 32'(id_valid), 32'd1);
        tick();
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        @(negedge clk);
        check("bp_req_resume", 32'(imem_req), 32'd1);
        repeat (6) @(negedge clk);
        check("bp_refilled", 32'(exp_q.size()), 32'd2);
        tick();
        id_ready = 1'b1;
        lat      = 3;

        // Redirect while waiting on memory: aligned target, returning word discarded.
        wait_grant("redir_wait_grant");
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        @(negedge clk);
        check("redir_wait_pc_write", 32'(pc_write), 32'd1);
        check("redir_wait_pc_next", pc_next, 32'h0000_0100);
        check("redir_wait_req", 32'(imem_req), 32'd0);
        tick();
        redirect = 1'b0;
        @(negedge clk);
        check("drain_req", 32'(imem_req), 32'd0);
        check("drain_id_valid", 32'(id_valid), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            seen = id_valid;
        end
        check("redir_first_valid", 32'(seen), 32'd1);
        check("redir_first_pc", id_pc, 32'h0000_0100);

        // Redirect in the same cycle as returning data.
        tick();
        lat = 1;
        wait_grant("redir_rv_grant");
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        @(negedge clk);
        check("redir_rv_req", 32'(imem_req), 32'd0);
        check("redir_rv_pc_next", pc_next, 32'h0000_0200);
        tick();
        redirect = 1'b0;
        @(negedge clk);
        check("redir_rv_fetch_req", 32'(imem_req), 32'd1);
        check("redir_rv_addr", imem_addr, 32'h0000_0200);
        check("redir_rv_id_valid", 32'(id_valid), 32'd0);

        // PC wrap at the top of the address space.
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        check("wrap_redir_pc_next", pc_next, 32'hFFFF_FFFC);
        tick();
        redirect = 1'b0;
        @(negedge clk);
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        check("wrap_pc_write", 32'(pc_write), 32'd1);
        check("wrap_pc_next", pc_next, 32'h0000_0000);

        // Reset while a request is outstanding.
        tick();
        lat = 5;
        wait_grant("rst_wait_grant");
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("rst_mid_id_valid", 32'(id_valid), 32'd0);
        check("rst_mid_req", 32'(imem_req), 32'd0);
        check("rst_mid_pc_write", 32'(pc_write), 32'd0);
        tick();
        rst = 1'b0;
        lat = 1;
        @(negedge clk);
        check("post_rst_req", 32'(imem_req), 32'd1);
        check("post_rst_id_valid", 32'(id_valid), 32'd0);

        // Run on, then stop granting and confirm every granted word reached decode.
        repeat (10) @(negedge clk);
        tick();
        gnt_en = 1'b0;
        repeat (6) @(negedge clk);
        check("final_all_delivered", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
